// File: rtl/lfsr_rand_pkg.sv
// rtl/lfsr_rand_pkg.sv - shared types and constants for the LFSR range sampler
package lfsr_rand_pkg;

  localparam int RND_MAX_WIDTH    = 16;
  localparam int REJECT_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [REJECT_CNT_WIDTH-1:0] sat_inc(
    input logic [REJECT_CNT_WIDTH-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/range_mask_gen.sv
// rtl/range_mask_gen.sv - smallest all-ones mask covering limit-1
module range_mask_gen #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] mask
);

  logic [WIDTH-1:0] limit_m1;

  // limit==0 wraps to all-ones, which is exactly the full-range mask.
  assign limit_m1 = limit - 1'b1;

  // Smear the highest set bit of limit-1 down through every lower bit.
  always_comb begin
    logic [WIDTH-1:0] acc;
    acc = limit_m1;
    for (int s = 1; s < WIDTH; s = s * 2) begin
      acc = acc | (acc >> s);
    end
    mask = acc;
  end

endmodule

// File: rtl/lfsr_range_sampler.sv
// rtl/lfsr_range_sampler.sv - bounded uniform integers from LFSR bits by masked rejection
module lfsr_range_sampler
  import lfsr_rand_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_TRIES = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [31:0]                 lfsr_state_i,
  input  logic [WIDTH-1:0]            limit_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  output logic                        rnd_valid_o,
  input  logic                        rnd_ready_i,
  output logic [WIDTH-1:0]            rnd_o,
  output logic                        rnd_fallback_o,
  output logic [REJECT_CNT_WIDTH-1:0] reject_cnt_o
);

  localparam logic [7:0] LAST_TRY = 8'(MAX_TRIES - 1);

  state_t state_q, state_d;

  logic [WIDTH-1:0]            limit_q, limit_d;
  logic [WIDTH-1:0]            mask_q, mask_d;
  logic [WIDTH-1:0]            mask_from_limit;
  logic [WIDTH-1:0]            rnd_q, rnd_d;
  logic                        fb_q, fb_d;
  logic [7:0]                  tries_q, tries_d;
  logic [REJECT_CNT_WIDTH-1:0] rej_q, rej_d;
  logic [WIDTH-1:0]            cand;
  logic                        cand_ok;
  logic                        unused_lfsr_bits;

  range_mask_gen #(
    .WIDTH(WIDTH)
  ) u_mask (
    .limit(limit_i),
    .mask (mask_from_limit)
  );

  assign cand             = lfsr_state_i[WIDTH-1:0] & mask_q;
  assign cand_ok          = (limit_q == '0) || (cand < limit_q);
  assign unused_lfsr_bits = ^lfsr_state_i[31:WIDTH];

  // Handshake outputs decode straight from state; data outputs come from registers.
  assign req_ready_o    = (state_q == IDLE);
  assign rnd_valid_o    = (state_q == DONE);
  assign rnd_o          = rnd_q;
  assign rnd_fallback_o = fb_q;
  assign reject_cnt_o   = rej_q;

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath update for one sampling step.
  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    mask_d  = mask_q;
    tries_d = tries_q;
    rnd_d   = rnd_q;
    fb_d    = fb_q;
    rej_d   = rej_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          limit_d = limit_i;
          mask_d  = mask_from_limit;
          tries_d = '0;
          state_d = SAMPLE;
        end
      end
      SAMPLE: begin
        if (cand_ok) begin
          rnd_d   = cand;
          fb_d    = 1'b0;
          state_d = DONE;
        end else begin
          rej_d   = sat_inc(rej_q);
          tries_d = tries_q + 8'd1;
          if (tries_q == LAST_TRY) begin
            // cand <= mask < 2*limit, so one subtraction lands in range.
            rnd_d   = cand - limit_q;
            fb_d    = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (rnd_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers; reset discards any in-flight request.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      limit_q <= '0;
      mask_q  <= '0;
      tries_q <= '0;
      rnd_q   <= '0;
      fb_q    <= 1'b0;
      rej_q   <= '0;
    end else begin
      limit_q <= limit_d;
      mask_q  <= mask_d;
      tries_q <= tries_d;
      rnd_q   <= rnd_d;
      fb_q    <= fb_d;
      rej_q   <= rej_d;
    end
  end

endmodule

// File: tb/tb_lfsr_range_sampler.sv
// tb/tb_lfsr_range_sampler.sv - directed self-checking bench for lfsr_range_sampler
module tb_lfsr_range_sampler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] lfsr = 32'h0;
  logic [7:0]  limit = 8'h0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        rnd_valid;
  logic        rnd_ready = 1'b0;
  logic [7:0]  rnd;
  logic        rnd_fb;
  logic [15:0] rej_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lfsr_range_sampler #(
    .WIDTH    (8),
    .MAX_TRIES(4)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .lfsr_state_i  (lfsr),
    .limit_i       (limit),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .rnd_valid_o   (rnd_valid),
    .rnd_ready_i   (rnd_ready),
    .rnd_o         (rnd),
    .rnd_fallback_o(rnd_fb),
    .reject_cnt_o  (rej_cnt)
  );

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 1'b0;
    rnd_ready = 1'b0;
    lfsr      = 32'h0;
    limit     = 8'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Issues one request and feeds s0..s3 (last repeated) as LFSR low bytes, one per
  // cycle. lat = index of the edge whose preceding cycle first shows rnd_valid
  // (accept edge is 0); 0 when nothing arrives. limit_i is disturbed after acceptance.
  task automatic run_request(input logic [7:0] lim, input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3,
                             output int lat, output logic acc_ok, output logic overlap);
    logic [7:0] s;
    @(negedge clk);
    limit     = lim;
    req_valid = 1'b1;
    rnd_ready = 1'b0;
    acc_ok    = req_ready;
    @(posedge clk);
    lat     = 0;
    overlap = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      limit     = 8'd2;
      if (rnd_valid && req_ready) overlap = 1'b1;
      if (rnd_valid) begin
        lat = i;
        break;
      end
      case (i)
        1:       s = s0;
        2:       s = s1;
        3:       s = s2;
        default: s = s3;
      endcase
      lfsr = {24'h00BACF, s};
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    rnd_ready = 1'b1;
    @(negedge clk);
    rnd_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks += 5;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    if (rnd_valid !== 1'b0) begin failures++; $display("FAIL reset_rnd_valid got=%b exp=0", rnd_valid); end
    if (rnd !== 8'd0) begin failures++; $display("FAIL reset_rnd got=%0d exp=0", rnd); end
    if (rnd_fb !== 1'b0) begin failures++; $display("FAIL reset_fallback got=%b exp=0", rnd_fb); end
    if (rej_cnt !== 16'd0) begin failures++; $display("FAIL reset_reject_cnt got=%0d exp=0", rej_cnt); end
  endtask

  task automatic test_accept_first();
    int lat; logic ok, ov;
    do_reset();
    run_request(8'd200, 8'hBD, 8'hBD, 8'hBD, 8'hBD, lat, ok, ov);
    checks += 6;
    if (ok !== 1'b1) begin failures++; $display("FAIL first_req_ready got=%b exp=1", ok); end
    if (lat !== 2) begin failures++; $display("FAIL first_latency got=%0d exp=2", lat); end
    if (rnd !== 8'd189) begin failures++; $display("FAIL first_rnd got=%0d exp=189", rnd); end
    if (rnd_fb !== 1'b0) begin failures++; $display("FAIL first_fallback got=%b exp=0", rnd_fb); end
    if (rej_cnt !== 16'd0) begin failures++; $display("FAIL first_reject_cnt got=%0d exp=0", rej_cnt); end
    if (ov !== 1'b0) begin failures++; $display("FAIL first_valid_with_ready got=%b exp=0", ov); end
    release_result();
  endtask

  task automatic test_single_reject();
    int lat; logic ok, ov;
    do_reset();
    run_request(8'd6, 8'h07, 8'h03, 8'h03, 8'h03, lat, ok, ov);
    checks += 4;
    if (lat !== 3) begin failures++; $display("FAIL reject1_latency got=%0d exp=3", lat); end
    if (rnd !== 8'd3) begin failures++; $display("FAIL reject1_rnd got=%0d exp=3", rnd); end
    if (rnd_fb !== 1'b0) begin failures++; $display("FAIL reject1_fallback got=%b exp=0", rnd_fb); end
    if (rej_cnt !== 16'd1) begin failures++; $display("FAIL reject1_reject_cnt got=%0d exp=1", rej_cnt); end
    release_result();
  endtask

  task automatic test_fallback();
    int lat; logic ok, ov;
    do_reset();
    run_request(8'd5, 8'h07, 8'h06, 8'h05, 8'h07, lat, ok, ov);
    checks += 4;
    if (lat !== 5) begin failures++; $display("FAIL fallback_latency got=%0d exp=5", lat); end
    if (rnd !== 8'd2) begin failures++; $display("FAIL fallback_rnd got=%0d exp=2", rnd); end
    if (rnd_fb !== 1'b1) begin failures++; $display("FAIL fallback_flag got=%b exp=1", rnd_fb); end
    if (rej_cnt !== 16'd4) begin failures++; $display("FAIL fallback_reject_cnt got=%0d exp=4", rej_cnt); end
  endtask

  // Entered with the fallback result still held (rnd=2, flag=1, count=4).
  task automatic test_reset_mid_sample();
    int lat; logic ok, ov; logic seen;
    release_result();
    @(negedge clk);
    limit     = 8'd5;
    lfsr      = 32'h00BACF07;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checks += 1;
    if (rej_cnt !== 16'd5) begin failures++; $display("FAIL midrst_pre_count got=%0d exp=5", rej_cnt); end
    reset = 1'b1;
    #1;
    checks += 5;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL midrst_req_ready got=%b exp=1", req_ready); end
    if (rnd_valid !== 1'b0) begin failures++; $display("FAIL midrst_rnd_valid got=%b exp=0", rnd_valid); end
    if (rnd !== 8'd0) begin failures++; $display("FAIL midrst_rnd got=%0d exp=0", rnd); end
    if (rnd_fb !== 1'b0) begin failures++; $display("FAIL midrst_fallback got=%b exp=0", rnd_fb); end
    if (rej_cnt !== 16'd0) begin failures++; $display("FAIL midrst_reject_cnt got=%0d exp=0", rej_cnt); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rnd_valid) seen = 1'b1;
    end
    checks += 1;
    if (seen !== 1'b0) begin failures++; $display("FAIL midrst_spurious_valid got=%b exp=0", seen); end
    run_request(8'd5, 8'h03, 8'h03, 8'h03, 8'h03, lat, ok, ov);
    checks += 3;
    if (lat !== 2) begin failures++; $display("FAIL midrst_after_latency got=%0d exp=2", lat); end
    if (rnd !== 8'd3) begin failures++; $display("FAIL midrst_after_rnd got=%0d exp=3", rnd); end
    if (rej_cnt !== 16'd0) begin failures++; $display("FAIL midrst_after_reject_cnt got=%0d exp=0", rej_cnt); end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat; logic ok, ov; logic bad;
    do_reset();
    run_request(8'd0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, lat, ok, ov);
    checks += 2;
    if (lat !== 2) begin failures++; $display("FAIL full_latency got=%0d exp=2", lat); end
    if (rnd !== 8'd255) begin failures++; $display("FAIL full_rnd got=%0d exp=255", rnd); end
    req_valid = 1'b1;
    limit     = 8'd1;
    bad       = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      lfsr = {24'h123456, 8'(8'h3C + i)};
      if (rnd !== 8'd255 || rnd_valid !== 1'b1 || req_ready !== 1'b0) bad = 1'b1;
    end
    checks += 1;
    if (bad !== 1'b0) begin failures++; $display("FAIL hold_stable got=%b exp=0 rnd=%0d", bad, rnd); end
    rnd_ready = 1'b1;
    @(negedge clk);
    rnd_ready = 1'b0;
    checks += 2;
    if (req_ready !== 1'b1) begin failures++; $display("FAIL b2b_idle_ready got=%b exp=1", req_ready); end
    if (rnd_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle_valid got=%b exp=0", rnd_valid); end
    @(negedge clk);
    req_valid = 1'b0;
    checks += 1;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL b2b_accepted got=%b exp=0", req_ready); end
    @(negedge clk);
    checks += 2;
    if (rnd_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%b exp=1", rnd_valid); end
    if (rnd !== 8'd0) begin failures++; $display("FAIL b2b_rnd got=%0d exp=0", rnd); end
    release_result();
  endtask

  task automatic test_limit_one();
    int lat; logic ok, ov;
    do_reset();
    run_request(8'd1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, lat, ok, ov);
    checks += 2;
    if (lat !== 2) begin failures++; $display("FAIL lim1a_latency got=%0d exp=2", lat); end
    if (rnd !== 8'd0) begin failures++; $display("FAIL lim1a_rnd got=%0d exp=0", rnd); end
    release_result();
    run_request(8'd1, 8'h5A, 8'h5A, 8'h5A, 8'h5A, lat, ok, ov);
    checks += 3;
    if (lat !== 2) begin failures++; $display("FAIL lim1b_latency got=%0d exp=2", lat); end
    if (rnd !== 8'd0) begin failures++; $display("FAIL lim1b_rnd got=%0d exp=0", rnd); end
    if (rej_cnt !== 16'd0) begin failures++; $display("FAIL lim1_reject_cnt got=%0d exp=0", rej_cnt); end
    release_result();
  endtask

  initial begin
    test_reset();
    test_accept_first();
    test_single_reject();
    test_fallback();
    test_reset_mid_sample();
    test_back_to_back();
    test_limit_one();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
